// File: rtl/stopwatch_timer_multi.sv
// stopwatch_timer_multi
//   One BCD mm:ss counter shared by a count-up stopwatch (with lap freeze)
//   and a count-down timer (validated preset load, expiry flag), plus a
//   free-running hh:mm:ss time-of-day counter. A registered 16-bit BCD
//   display bus feeds the downstream 7-segment decoders.
//
// Parameters
//   TICK_DIV  clk cycles per 1 s tick (>=2)
//   MM_MAX    highest minute value of the timer counter (1..99)
//   SW_WRAP   1: stopwatch wraps to 00:00 and pulses rollover
//             0: stopwatch holds at MM_MAX:59 and expires
//
// Ports
//   clk, reset       clock, asynchronous active-low reset
//   mode[1:0]        00 stopwatch, 01 countdown, 1x time-of-day
//   start/pause/clear/load/lap   one-cycle command pulses
//   load_bcd[15:0]   {tens_hi, ones_hi, tens_lo, ones_lo}
//   disp_bcd[15:0]   displayed value, same digit order as load_bcd
//   running          timer FSM in RUN
//   expired          timer FSM in EXPIRED
//   rollover         one-cycle pulse on stopwatch wrap
//   load_err         one-cycle pulse on a rejected load
//   lap_hold         stopwatch display frozen on the lap capture
module stopwatch_timer_multi #(
    parameter int TICK_DIV = 50000000,
    parameter int MM_MAX   = 59,
    parameter int SW_WRAP  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_bcd,
    input  logic        lap,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        expired,
    output logic        rollover,
    output logic        load_err,
    output logic        lap_hold
);
    localparam int              TPW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TPW-1:0]  TICK_LAST = TPW'(TICK_DIV - 1);
    localparam logic [3:0]      MAX_T     = 4'(MM_MAX / 10);
    localparam logic [3:0]      MAX_O     = 4'(MM_MAX % 10);
    localparam logic [15:0]     SW_LIMIT  = {MAX_T, MAX_O, 8'h59};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

    state_t         r_state, w_state_n;
    logic [15:0]    r_cnt, w_cnt_n;
    logic [15:0]    r_lap, w_lap_n;
    logic           r_lap_hold, w_lap_hold_n;
    logic           r_roll, w_roll_n;
    logic           r_lerr, w_lerr_n;
    logic           r_cd;           // last timer mode seen: 1 = countdown
    logic [TPW-1:0] r_tpre, r_dpre;
    logic [7:0]     r_hh, r_mm, r_ss;
    logic [15:0]    r_disp, w_disp_n;

    // ---------------------------------------------------------------- BCD helpers
    // {carry, next} for a 00..59 field
    function automatic logic [8:0] f_inc60(input logic [7:0] v);
        if (v == 8'h59)      return 9'h100;
        if (v[3:0] == 4'd9)  return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] f_inc99(input logic [7:0] v);
        if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // {borrow, next} for a 00..59 field
    function automatic logic [8:0] f_dec60(input logic [7:0] v);
        if (v == 8'h00)      return {1'b1, 8'h59};
        if (v[3:0] == 4'd0)  return {1'b0, v[7:4] - 4'd1, 4'd9};
        return {1'b0, v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] f_dec99(input logic [7:0] v);
        if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic f_digits_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
               (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // ---------------------------------------------------------------- decode
    logic        w_cd, w_mode_sw, w_ttick, w_dtick;
    logic        w_tl_ok, w_tod_ok, w_tod_ld;
    logic [7:0]  w_ld_min;
    logic [8:0]  w_sec_inc, w_sec_dec, w_tss_inc, w_tmm_inc;
    logic [15:0] w_sw_inc, w_cd_dec;

    // In mode 1x the timer keeps whichever flavour it was last running as.
    assign w_cd      = mode[1] ? r_cd : mode[0];
    assign w_mode_sw = !mode[1] && (mode[0] != r_cd) && (r_state != S_IDLE);
    assign w_ttick   = (r_state == S_RUN) && (r_tpre == TICK_LAST);
    assign w_dtick   = (r_dpre == TICK_LAST);

    assign w_ld_min  = 8'(load_bcd[15:12]) * 8'd10 + 8'(load_bcd[11:8]);
    assign w_tl_ok   = f_digits_ok(load_bcd) && (load_bcd[7:4] <= 4'd5) &&
                       (w_ld_min <= 8'(MM_MAX));
    // With valid digits, BCD byte compares order the same as the numbers.
    assign w_tod_ok  = f_digits_ok(load_bcd) && (load_bcd[15:8] <= 8'h23) &&
                       (load_bcd[7:4] <= 4'd5);
    assign w_tod_ld  = load && !clear && mode[1] && w_tod_ok;

    assign w_sec_inc = f_inc60(r_cnt[7:0]);
    assign w_sw_inc  = {w_sec_inc[8] ? f_inc99(r_cnt[15:8]) : r_cnt[15:8], w_sec_inc[7:0]};
    assign w_sec_dec = f_dec60(r_cnt[7:0]);
    assign w_cd_dec  = {w_sec_dec[8] ? f_dec99(r_cnt[15:8]) : r_cnt[15:8], w_sec_dec[7:0]};

    assign w_tss_inc = f_inc60(r_ss);
    assign w_tmm_inc = f_inc60(r_mm);

    // ---------------------------------------------------------------- timer FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_n;
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_lap_n      = r_lap;
        w_lap_hold_n = r_lap_hold;
        w_roll_n     = 1'b0;
        w_lerr_n     = 1'b0;

        // The tick lands first; commands below may then override it.
        if (w_ttick) begin
            if (!r_cd) begin
                if (r_cnt == SW_LIMIT) begin
                    if (SW_WRAP != 0) begin
                        w_cnt_n  = '0;
                        w_roll_n = 1'b1;
                    end else begin
                        w_state_n = S_EXPIRED;
                    end
                end else begin
                    w_cnt_n = w_sw_inc;
                end
            end else if (r_cnt == 16'h0000) begin
                w_state_n = S_EXPIRED;
            end else begin
                w_cnt_n = w_cd_dec;
                if (r_cnt == 16'h0001) w_state_n = S_EXPIRED;
            end
        end

        if (clear || w_mode_sw) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_roll_n  = 1'b0;
        end else if (load) begin
            if (mode[1])
                w_lerr_n = !w_tod_ok;
            else if (r_state != S_RUN && w_tl_ok) begin
                w_cnt_n   = load_bcd;
                w_state_n = S_IDLE;
            end else
                w_lerr_n = 1'b1;
        end else if (pause) begin
            // An expiring tick in the same cycle keeps EXPIRED.
            if (r_state == S_RUN && w_state_n == S_RUN) w_state_n = S_PAUSED;
        end else if (start) begin
            if (r_state == S_PAUSED ||
                (r_state == S_IDLE && !(w_cd && r_cnt == 16'h0000)))
                w_state_n = S_RUN;
        end

        if (lap && mode == 2'b00 && r_state == S_RUN && !clear && !w_mode_sw) begin
            w_lap_hold_n = !r_lap_hold;
            if (!r_lap_hold) w_lap_n = r_cnt;
        end
        // Only pause keeps the freeze when leaving RUN.
        if (w_state_n == S_IDLE || w_state_n == S_EXPIRED) w_lap_hold_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_lap      <= '0;
            r_lap_hold <= 1'b0;
            r_roll     <= 1'b0;
            r_lerr     <= 1'b0;
            r_cd       <= 1'b0;
            r_tpre     <= '0;
        end else begin
            r_cnt      <= w_cnt_n;
            r_lap      <= w_lap_n;
            r_lap_hold <= w_lap_hold_n;
            r_roll     <= w_roll_n;
            r_lerr     <= w_lerr_n;
            if (!mode[1]) r_cd <= mode[0];
            // Zero outside RUN/PAUSED so IDLE->RUN starts a fresh second,
            // held in PAUSED so a resume continues the partial second.
            case (r_state)
                S_RUN:    r_tpre <= w_ttick ? '0 : r_tpre + TPW'(1);
                S_PAUSED: r_tpre <= r_tpre;
                default:  r_tpre <= '0;
            endcase
        end
    end

    // ---------------------------------------------------------------- time of day
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dpre <= '0;
            r_hh   <= '0;
            r_mm   <= '0;
            r_ss   <= '0;
        end else if (w_tod_ld) begin
            r_dpre <= '0;
            r_hh   <= load_bcd[15:8];
            r_mm   <= load_bcd[7:0];
            r_ss   <= '0;
        end else begin
            r_dpre <= w_dtick ? '0 : r_dpre + TPW'(1);
            if (w_dtick) begin
                r_ss <= w_tss_inc[7:0];
                if (w_tss_inc[8]) begin
                    r_mm <= w_tmm_inc[7:0];
                    if (w_tmm_inc[8]) r_hh <= (r_hh == 8'h23) ? 8'h00 : f_inc99(r_hh);
                end
            end
        end
    end

    // ---------------------------------------------------------------- display
    always_comb begin
        w_disp_n = r_cnt;
        if (mode[1])                     w_disp_n = {r_hh, r_mm};
        else if (!mode[0] && r_lap_hold) w_disp_n = r_lap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_disp <= '0;
        else        r_disp <= w_disp_n;
    end

    assign disp_bcd = r_disp;
    assign running  = (r_state == S_RUN);
    assign expired  = (r_state == S_EXPIRED);
    assign rollover = r_roll;
    assign load_err = r_lerr;
    assign lap_hold = r_lap_hold;

endmodule

// File: tb/tb_stopwatch_timer_multi.sv
// Bench for stopwatch_timer_multi. Three instances share one stimulus stream:
//   [0] TICK_DIV=4 MM_MAX=59 SW_WRAP=1
//   [1] TICK_DIV=4 MM_MAX=1  SW_WRAP=1
//   [2] TICK_DIV=4 MM_MAX=1  SW_WRAP=0
// Expected values are queued as stimulus is driven and popped when sampled.
module tb_stopwatch_timer_multi;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        start, pause, clear, load, lap;
    logic [15:0] load_bcd;

    logic [2:0][15:0] disp;
    logic [2:0]       run, expd, roll, lerr, lhold;
    logic [2:0][4:0]  fl;

    localparam logic [4:0] F_RUN  = 5'b10000;
    localparam logic [4:0] F_EXP  = 5'b01000;
    localparam logic [4:0] F_LERR = 5'b00010;
    localparam logic [4:0] F_LAP  = 5'b00001;
    // cmd vector order: {clear, load, pause, start, lap}
    localparam logic [4:0] C_CLR  = 5'b10000;
    localparam logic [4:0] C_LD   = 5'b01000;
    localparam logic [4:0] C_PS   = 5'b00100;
    localparam logic [4:0] C_ST   = 5'b00010;
    localparam logic [4:0] C_LAP  = 5'b00001;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        stopwatch_timer_multi #(
            .TICK_DIV (4),
            .MM_MAX   (g == 0 ? 59 : 1),
            .SW_WRAP  (g == 2 ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .reset    (rst_n),
            .mode     (mode),
            .start    (start),
            .pause    (pause),
            .clear    (clear),
            .load     (load),
            .load_bcd (load_bcd),
            .lap      (lap),
            .disp_bcd (disp[g]),
            .running  (run[g]),
            .expired  (expd[g]),
            .rollover (roll[g]),
            .load_err (lerr[g]),
            .lap_hold (lhold[g])
        );
        assign fl[g] = {run[g], expd[g], roll[g], lerr[g], lhold[g]};
    end

    always #5 clk = ~clk;

    int roll_cnt = 0;
    always @(negedge clk) if (roll[1]) roll_cnt++;

    typedef struct { string tag; logic [15:0] exp; } sb_t;
    sb_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic push(input string tag, input logic [15:0] e);
        sb.push_back('{tag, e});
    endtask

    task automatic observe(input logic [15:0] obs);
        sb_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [4:0] c);
        {clear, load, pause, start, lap} = c;
        step(1);
        {clear, load, pause, start, lap} = '0;
    endtask

    int roll_base;

    initial begin
        mode = 2'b00; load_bcd = '0;
        {clear, load, pause, start, lap} = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // reset state
        push("rst_disp0", 16'h0000); push("rst_flags0", 16'h0000);
        push("rst_flags2", 16'h0000);
        step(2);
        observe(disp[0]); observe({11'b0, fl[0]}); observe({11'b0, fl[2]});
        rst_n = 1'b1;
        step(1);

        // stopwatch: 60 ticks -> 01:00, then pause holds it
        cmd(C_ST);
        push("sw60_disp0", 16'h0100); push("sw60_flags0", 16'(F_RUN));
        push("sw60_disp1", 16'h0100);
        step(241);
        observe(disp[0]); observe({11'b0, fl[0]}); observe(disp[1]);
        cmd(C_PS);
        push("pause_disp0", 16'h0100); push("pause_flags0", 16'h0000);
        step(20);
        observe(disp[0]); observe({11'b0, fl[0]});

        // wrap (inst 1) versus hold-and-expire (inst 2) after 120 ticks
        cmd(C_CLR);
        roll_base = roll_cnt;
        cmd(C_ST);
        push("wrap_disp1", 16'h0000); push("wrap_flags1", 16'(F_RUN));
        push("wrap_rollcnt", 16'd1);
        push("hold_disp2", 16'h0159); push("hold_flags2", 16'(F_EXP));
        push("sw120_disp0", 16'h0200);
        step(481);
        observe(disp[1]); observe({11'b0, fl[1]}); observe(16'(roll_cnt - roll_base));
        observe(disp[2]); observe({11'b0, fl[2]});
        observe(disp[0]);

        // countdown 00:05
        cmd(C_CLR);
        mode = 2'b01; load_bcd = 16'h0005;
        cmd(C_LD);
        cmd(C_ST);
        push("cd4_disp0", 16'h0001); push("cd4_flags0", 16'(F_RUN));
        step(17);
        observe(disp[0]); observe({11'b0, fl[0]});
        push("cd5_disp0", 16'h0000); push("cd5_flags0", 16'(F_EXP));
        push("cd5_flags2", 16'(F_EXP));
        step(4);
        observe(disp[0]); observe({11'b0, fl[0]}); observe({11'b0, fl[2]});
        cmd(C_ST);
        push("cd_restart_disp0", 16'h0000); push("cd_restart_flags0", 16'(F_EXP));
        step(2);
        observe(disp[0]); observe({11'b0, fl[0]});
        cmd(C_CLR);
        push("cd_clear_flags0", 16'h0000);
        observe({11'b0, fl[0]});
        cmd(C_ST);
        push("cd_start_zero_flags0", 16'h0000);
        step(2);
        observe({11'b0, fl[0]});

        // invalid countdown preset
        load_bcd = 16'h0012; cmd(C_LD);
        load_bcd = 16'h0070; cmd(C_LD);
        push("ld0070_flags0", 16'(F_LERR)); push("ld0070_flags1", 16'(F_LERR));
        observe({11'b0, fl[0]}); observe({11'b0, fl[1]});
        push("ld0070_disp0", 16'h0012); push("ld0070_pulse0", 16'h0000);
        step(1);
        observe(disp[0]); observe({11'b0, fl[0]});

        // time of day: 23:59 + 60 s -> 00:00, then invalid 24:00
        mode = 2'b10; load_bcd = 16'h2359;
        cmd(C_LD);
        push("tod_pre_disp0", 16'h2359);
        step(237);
        observe(disp[0]);
        push("tod_wrap_disp0", 16'h0000); push("tod_wrap_disp2", 16'h0000);
        step(4);
        observe(disp[0]); observe(disp[2]);
        load_bcd = 16'h2400; cmd(C_LD);
        push("ld2400_flags0", 16'(F_LERR));
        observe({11'b0, fl[0]});
        push("ld2400_disp0", 16'h0000);
        step(1);
        observe(disp[0]);

        // stopwatch: load while RUN rejected, lap freeze and release
        mode = 2'b00;
        cmd(C_CLR);
        cmd(C_ST);
        load_bcd = 16'h0030; cmd(C_LD);
        push("ldrun_flags0", 16'(F_RUN | F_LERR));
        observe({11'b0, fl[0]});
        step(11);
        cmd(C_LAP);
        push("lap_on_flags0", 16'(F_RUN | F_LAP));
        observe({11'b0, fl[0]});
        push("lap_frozen_disp0", 16'h0003);
        step(16);
        observe(disp[0]);
        cmd(C_LAP);
        push("lap_off_disp0", 16'h0007); push("lap_off_flags0", 16'(F_RUN));
        step(1);
        observe(disp[0]); observe({11'b0, fl[0]});

        // 00 -> 01 while running forces IDLE at 00:00
        mode = 2'b01;
        push("msw_disp0", 16'h0000); push("msw_flags0", 16'h0000);
        step(2);
        observe(disp[0]); observe({11'b0, fl[0]});

        // asynchronous reset mid-run, checked before any clock edge
        mode = 2'b00;
        cmd(C_ST);
        push("prerst_disp0", 16'h0002);
        step(10);
        observe(disp[0]);
        push("arst_disp0", 16'h0000); push("arst_flags0", 16'h0000);
        push("arst_disp1", 16'h0000);
        rst_n = 1'b0;
        #2;
        observe(disp[0]); observe({11'b0, fl[0]}); observe(disp[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/stopwatch_timer_multi.md
Name: stopwatch_timer_multi

Overview:
Parametrised successor to the single-purpose stopwatch. One BCD mm:ss counter serves two modes: a count-up stopwatch with lap freeze, and a count-down timer with validated preset load and an expiry flag. A free-running hh:mm time-of-day counter runs alongside it. The block feeds the existing 7-segment decode blocks through a 16-bit BCD display bus selected by mode.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick (>=2)
MM_MAX, 59, highest minute value for stopwatch/countdown (1..99)
SW_WRAP, 1, 1: stopwatch wraps MM_MAX:59 -> 00:00 and pulses rollover; 0: stopwatch stops in EXPIRED

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
mode  in  2  00 stopwatch, 01 countdown, 10 time-of-day display/set, 11 treated as 10
start  in  1  one-cycle pulse, start/resume
pause  in  1  one-cycle pulse, pause
clear  in  1  one-cycle pulse, return to IDLE at 00:00
load  in  1  one-cycle pulse, load load_bcd into selected counter
load_bcd  in  16  {tens_hi, ones_hi, tens_lo, ones_lo} BCD
lap  in  1  one-cycle pulse, toggle lap freeze (stopwatch only)
disp_bcd  out  16  displayed value, same digit order as load_bcd
running  out  1  timer FSM in RUN
expired  out  1  countdown reached 00:00, or stopwatch limit with SW_WRAP=0
rollover  out  1  one-cycle pulse on stopwatch wrap
load_err  out  1  one-cycle pulse on rejected load
lap_hold  out  1  display frozen

Behaviour:
- Reset (reset=0, async): timer count 00:00, TOD 00:00:00, prescalers 0, FSM IDLE, all outputs 0, disp_bcd 0000.
- Prescalers: timer prescaler and TOD prescaler each count 0..TICK_DIV-1. A tick is the cycle where count = TICK_DIV-1. Timer prescaler advances only in RUN. It is cleared on IDLE->RUN and held on PAUSED->RUN. The TOD prescaler always runs.
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
- Command priority, one command acts per cycle: clear > load > pause > start.
- clear: any state -> IDLE; count 00:00; expired, lap_hold cleared.
- start: IDLE/PAUSED -> RUN. In countdown, start with count 00:00 is ignored and the FSM stays IDLE. start in RUN or EXPIRED has no effect.
- pause: RUN -> PAUSED; ignored elsewhere.
- Stopwatch tick: ss+1. At ss=59: ss=00, mm+1. At MM_MAX:59:
  - SW_WRAP=1: count -> 00:00, rollover=1 for one cycle, FSM stays in RUN.
  - SW_WRAP=0: count holds at MM_MAX:59, FSM -> EXPIRED, expired=1.
- Countdown tick: ss-1. At ss=00: ss=59, mm-1. Tick at 00:01 -> count 00:00, FSM -> EXPIRED, expired=1 in the cycle after the tick. expired holds until clear or a valid load.
- Timer load (mode 00/01): accepted only in IDLE, PAUSED or EXPIRED.
  - Valid when every digit <=9, seconds tens <=5 and minutes <= MM_MAX. Valid load sets the count the next cycle, FSM -> IDLE, expired cleared.
  - Invalid load, or load in RUN: count unchanged, load_err pulses 1 cycle.
- TOD load (mode 1x): valid when hh<=23 and mm<=59, in any timer state. Valid load sets hh:mm, clears TOD seconds and the TOD prescaler. Invalid load pulses load_err. The timer FSM is unaffected.
- TOD counting: each tick ss+1. 59 -> mm+1. mm 59 -> hh+1. 23:59:59 -> 00:00:00. TOD counts regardless of mode.
- Lap: in mode 00 with FSM in RUN, lap toggles lap_hold. On the rising toggle the current count is captured and disp_bcd shows the captured value while counting continues. The next lap releases the freeze. lap is ignored in other modes and states. Leaving RUN for any reason other than pause clears lap_hold.
- Mode switch between 00 and 01 while not IDLE: forced IDLE, count 00:00, expired and lap_hold cleared. Switching to or from 1x leaves the timer running.
- disp_bcd: mode 00 shows the lap capture if lap_hold, otherwise the count. Mode 01 shows the count. Mode 1x shows TOD hh:mm. disp_bcd is registered and updates one cycle after the count changes.
- Simultaneous tick and pause: the tick is applied, then the FSM enters PAUSED.
- Simultaneous tick and clear: clear wins.
- Digits are stored as BCD throughout. There is no binary-to-BCD conversion path.

Test Plan:
- TICK_DIV=4, stopwatch: reset, start, run 240 cycles (60 ticks) -> disp_bcd 0100, running=1. Pause, idle 20 cycles -> value unchanged.
- TICK_DIV=4, MM_MAX=1, SW_WRAP=1: start, run 120 ticks -> disp_bcd 0000 with a single rollover pulse at the wrap. Repeat with SW_WRAP=0 -> holds 0159, expired=1, running=0.
- Countdown: load 0005, start, 5 ticks -> 0000, expired=1. Start again -> no change. Clear -> expired=0, IDLE.
- Invalid loads: 0070 (ss=70) in mode 01, 2400 in mode 10, and 0030 while RUN -> load_err pulses each time, values unchanged.
- Lap: stopwatch at 0003, lap -> display frozen at 0003 for 4 ticks while the count reaches 0007. Second lap -> display 0007.
- TOD: load 2359 in mode 10, 60 ticks -> 0000. Assert reset mid-run -> all outputs 0 with no clock edge.
